// File: rtl/sent_rx_host_pkg.sv
// Shared types and widths for the SENT receiver host buffer.
// Optional macro SENT_RX_HOST_TIMESTAMP_EN widens FIFO entries with a timestamp.
package sent_rx_host_pkg;
  localparam int FAST_W      = 12;
  localparam int SLOW_ID_W   = 8;
  localparam int SLOW_DATA_W = 16;
  localparam int TS_W        = 16;

  typedef struct packed {
    logic [SLOW_ID_W-1:0]   id;
    logic [SLOW_DATA_W-1:0] data;
    logic                   cfg;
    logic                   fmt;
    logic                   pause;
  } slow_msg_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } slow_state_t;
endpackage

// File: rtl/sent_rx_host_fifo.sv
// Synchronous first-word-fall-through FIFO with level, full and drop report.
// Head data reads as zero while empty.
module sent_rx_host_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dout,
  output logic [LW-1:0]    o_level,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [AW:0]      w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  assign w_level = r_wr - r_rd;
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_empty = (r_wr == r_rd);
  assign w_pop   = !w_empty && i_ready;
  assign w_push  = i_we && (!w_full || w_pop);

  assign o_valid = !w_empty;
  assign o_dout  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign o_level = LW'(w_level);
  assign o_drop  = i_we && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/sent_rx_host_buffer.sv
// Host-side buffer: fast-word FIFO, held slow message, sticky loss flags.
// Define SENT_RX_HOST_TIMESTAMP_EN to timestamp each FIFO entry.
import sent_rx_host_pkg::*;

module sent_rx_host_buffer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int AFULL_LEVEL = 12,
  parameter int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk_rx,
  input  logic                   reset_rx,
  input  logic                   write_enable_rx,
  input  logic [FAST_W-1:0]      data_to_fifo_rx,
  input  logic [SLOW_ID_W-1:0]   id_received,
  input  logic [SLOW_DATA_W-1:0] data_received,
  input  logic                   config_bit_received,
  input  logic                   channel_format_received,
  input  logic                   pause_received,
  output logic                   fast_valid,
  output logic [FAST_W-1:0]      fast_data,
  input  logic                   fast_ready,
`ifdef SENT_RX_HOST_TIMESTAMP_EN
  output logic [TS_W-1:0]        fast_timestamp,
`endif
  output logic [LW-1:0]          fifo_level,
  output logic                   fifo_afull,
  output logic                   fast_overflow,
  output logic                   slow_valid,
  output logic [SLOW_ID_W-1:0]   slow_id,
  output logic [SLOW_DATA_W-1:0] slow_data,
  output logic                   slow_cfg,
  output logic                   slow_fmt,
  output logic                   slow_pause,
  input  logic                   slow_ack,
  output logic                   slow_lost,
  input  logic                   status_clr
);
`ifdef SENT_RX_HOST_TIMESTAMP_EN
  localparam int EW = FAST_W + TS_W;
  logic [TS_W-1:0] r_ts;
  logic [EW-1:0]   w_din;
  logic [EW-1:0]   w_dout;

  always_ff @(posedge clk_rx) begin
    if (reset_rx) r_ts <= '0;
    else          r_ts <= r_ts + 1'b1;
  end

  assign w_din          = {r_ts, data_to_fifo_rx};
  assign fast_data      = w_dout[FAST_W-1:0];
  assign fast_timestamp = w_dout[EW-1:FAST_W];
`else
  localparam int EW = FAST_W;
  logic [EW-1:0] w_din;
  logic [EW-1:0] w_dout;

  assign w_din     = data_to_fifo_rx;
  assign fast_data = w_dout;
`endif

  logic w_drop;

  sent_rx_host_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk_rx),
    .rst     (reset_rx),
    .i_we    (write_enable_rx),
    .i_din   (w_din),
    .i_ready (fast_ready),
    .o_valid (fast_valid),
    .o_dout  (w_dout),
    .o_level (fifo_level),
    .o_drop  (w_drop)
  );

  assign fifo_afull = (fifo_level >= LW'(AFULL_LEVEL));

  always_ff @(posedge clk_rx) begin
    if (reset_rx)        fast_overflow <= 1'b0;
    else if (w_drop)     fast_overflow <= 1'b1;
    else if (status_clr) fast_overflow <= 1'b0;
  end

  slow_msg_t   w_msg;
  slow_msg_t   r_shadow;
  slow_msg_t   r_msg;
  slow_msg_t   r_held;
  logic        w_new_now;
  logic        r_new;
  slow_state_t r_state;
  slow_state_t w_next;
  logic        w_latch;
  logic        w_lost;

  assign w_msg     = '{id_received, data_received, config_bit_received,
                       channel_format_received, pause_received};
  assign w_new_now = (w_msg != r_shadow);

  // Shadow resets to zero so an idle all-zero bus is never reported.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      r_shadow <= '0;
      r_msg    <= '0;
      r_new    <= 1'b0;
    end else begin
      r_new <= w_new_now;
      if (w_new_now) begin
        r_shadow <= w_msg;
        r_msg    <= w_msg;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_lost  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_new) begin
          w_next  = HOLD;
          w_latch = 1'b1;
        end
      end
      HOLD: begin
        if (slow_ack) begin
          if (r_new) w_latch = 1'b1;
          else       w_next  = IDLE;
        end else if (r_new) begin
          w_lost = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      r_state   <= IDLE;
      r_held    <= '0;
      slow_lost <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch)         r_held    <= r_msg;
      if (w_lost)          slow_lost <= 1'b1;
      else if (status_clr) slow_lost <= 1'b0;
    end
  end

  assign slow_valid = (r_state == HOLD);
  assign slow_id    = r_held.id;
  assign slow_data  = r_held.data;
  assign slow_cfg   = r_held.cfg;
  assign slow_fmt   = r_held.fmt;
  assign slow_pause = r_held.pause;
endmodule
